// File: rtl/control_unit.sv
// rtl/control_unit.sv - instruction decoder, condition check and stored NZCV flags
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  Flags
);

  logic [3:0] cond;
  logic [1:0] op;
  logic       imm_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] rd;
  logic [1:0] shift_type;

  assign cond       = Instr[31:28];
  assign op         = Instr[27:26];
  assign imm_bit    = Instr[25];
  assign cmd        = Instr[24:21];
  assign s_bit      = Instr[20];
  assign rd         = Instr[15:12];
  assign shift_type = Instr[6:5];

  // Operand-register and shift-amount fields belong to the datapath, not the decoder.
  logic unused_bits;
  assign unused_bits = ^{Instr[19:16], Instr[11:7], Instr[4:0]};

  logic       branch;
  logic       reg_w;
  logic       mem_w;
  logic       alu_op;
  logic [1:0] flag_w;

  always_comb begin
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrc     = 1'b0;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = 3'b000;
    flag_w     = 2'b00;

    case (op)
      2'b00: begin
        reg_w  = 1'b1;
        ALUSrc = imm_bit;
        alu_op = 1'b1;
      end
      2'b01: begin
        ALUSrc = 1'b1;
        ImmSrc = 2'b01;
        if (s_bit) begin
          reg_w    = 1'b1;
          MemtoReg = 1'b1;
        end else begin
          mem_w  = 1'b1;
          RegSrc = 2'b10;
        end
      end
      2'b10: begin
        branch = 1'b1;
        ALUSrc = 1'b1;
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: ;
    endcase

    if (alu_op) begin
      case (cmd)
        4'b0100: begin
          ALUControl = 3'b000;
          flag_w     = s_bit ? 2'b11 : 2'b00;
        end
        4'b0010: begin
          ALUControl = 3'b001;
          flag_w     = s_bit ? 2'b11 : 2'b00;
        end
        4'b0000: begin
          ALUControl = 3'b010;
          flag_w     = s_bit ? 2'b10 : 2'b00;
        end
        4'b1100: begin
          ALUControl = 3'b011;
          flag_w     = s_bit ? 2'b10 : 2'b00;
        end
        4'b1010: begin
          // Compare only sets flags; it never writes a register.
          ALUControl = 3'b001;
          flag_w     = 2'b11;
          reg_w      = 1'b0;
        end
        4'b1101: begin
          flag_w = s_bit ? 2'b10 : 2'b00;
          if (imm_bit) begin
            ALUControl = 3'b100;
          end else begin
            case (shift_type)
              2'b00:   ALUControl = 3'b101;
              2'b01:   ALUControl = 3'b110;
              2'b10:   ALUControl = 3'b111;
              default: ALUControl = 3'b100;
            endcase
          end
        end
        default: reg_w = 1'b0;
      endcase
    end
  end

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;

  assign {flag_n, flag_z, flag_c, flag_v} = Flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic pcs;
  assign pcs = branch | (reg_w & (rd == 4'b1111));

  assign PCSrc    = pcs   & cond_ex & ~reset;
  assign RegWrite = reg_w & cond_ex & ~reset;
  assign MemWrite = mem_w & cond_ex & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (flag_w[1] & cond_ex) Flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] & cond_ex) Flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc;
  logic [1:0]  ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  Flags;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .Flags(Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change after the falling edge; combinational outputs are sampled 1 time unit later.
  task automatic apply(input logic [31:0] instr, input logic [3:0] aflags);
    @(negedge clk);
    Instr    = instr;
    ALUFlags = aflags;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    Instr    = 32'h0;
    ALUFlags = 4'h0;
    tick();
    check("reset_flags", Flags, 4'b0000);

    apply(32'hE3520000, 4'b1111);
    check("reset_gate_regwrite", RegWrite, 0);
    tick();
    check("reset_discards_update", Flags, 4'b0000);

    apply(32'hE0812003, 4'b0000);
    reset = 1'b0;
    #1;
    check("add_regwrite", RegWrite, 1);
    check("add_aluctl", ALUControl, 3'b000);
    check("add_alusrc", ALUSrc, 0);
    check("add_pcsrc", PCSrc, 0);
    check("add_memwrite", MemWrite, 0);

    apply(32'h0A000002, 4'b0100);
    check("beq_z0_pcsrc", PCSrc, 0);
    apply(32'h1A000002, 4'b0100);
    check("bne_z0_pcsrc", PCSrc, 1);

    apply(32'hE3520000, 4'b0100);
    check("cmp_regwrite", RegWrite, 0);
    check("cmp_aluctl", ALUControl, 3'b001);
    check("cmp_alusrc", ALUSrc, 1);
    check("cmp_flags_before_edge", Flags, 4'b0000);
    tick();
    check("cmp_flags", Flags, 4'b0100);

    apply(32'h0A000002, 4'b0000);
    check("beq_pcsrc", PCSrc, 1);
    check("beq_immsrc", ImmSrc, 2'b10);
    check("beq_regsrc", RegSrc, 2'b01);
    check("beq_regwrite", RegWrite, 0);

    apply(32'h10912003, 4'b1111);
    check("addsne_regwrite", RegWrite, 0);
    tick();
    check("addsne_no_update", Flags, 4'b0100);

    apply(32'hE5821000, 4'b0000);
    check("str_memwrite", MemWrite, 1);
    check("str_regsrc", RegSrc, 2'b10);
    check("str_alusrc", ALUSrc, 1);
    check("str_immsrc", ImmSrc, 2'b01);
    check("str_regwrite", RegWrite, 0);
    apply(32'hE5921000, 4'b0000);
    check("ldr_regwrite", RegWrite, 1);
    check("ldr_memtoreg", MemtoReg, 1);
    check("ldr_memwrite", MemWrite, 0);

    apply(32'hE1A01142, 4'b0000);
    check("mov_asr_aluctl", ALUControl, 3'b111);
    apply(32'hE1A01122, 4'b0000);
    check("mov_lsr_aluctl", ALUControl, 3'b110);
    apply(32'hE1A01002, 4'b0000);
    check("mov_lsl_aluctl", ALUControl, 3'b101);
    apply(32'hE3A01005, 4'b0000);
    check("mov_imm_aluctl", ALUControl, 3'b100);

    apply(32'hE0812003, 4'b0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rereset_flags", Flags, 4'b0000);
    apply(32'hE1B010A2, 4'b1011);
    check("movs_lsr_aluctl", ALUControl, 3'b110);
    tick();
    check("movs_flags_nz_only", Flags, 4'b1000);

    apply(32'hE0112003, 4'b0111);
    check("ands_aluctl", ALUControl, 3'b010);
    tick();
    check("ands_flags", Flags, 4'b0100);

    apply(32'hE0512003, 4'b0011);
    tick();
    check("subs_flags", Flags, 4'b0011);

    apply(32'h8A000002, 4'b0000);
    check("bhi_pcsrc", PCSrc, 1);
    apply(32'hAA000002, 4'b0000);
    check("bge_pcsrc", PCSrc, 0);
    apply(32'hBA000002, 4'b0000);
    check("blt_pcsrc", PCSrc, 1);
    apply(32'hFA000002, 4'b0000);
    check("bnv_pcsrc", PCSrc, 0);

    apply(32'hEC000000, 4'b0000);
    check("undef_regwrite", RegWrite, 0);
    check("undef_memwrite", MemWrite, 0);
    check("undef_pcsrc", PCSrc, 0);
    check("undef_alusrc", ALUSrc, 0);
    check("undef_aluctl", ALUControl, 3'b000);

    apply(32'hE0312003, 4'b1100);
    check("eors_regwrite", RegWrite, 0);
    check("eors_aluctl", ALUControl, 3'b000);
    tick();
    check("eors_no_update", Flags, 4'b0011);

    apply(32'hE1A0F000, 4'b0000);
    check("movpc_pcsrc", PCSrc, 1);
    check("movpc_regwrite", RegWrite, 1);
    reset = 1'b1;
    #1;
    check("movpc_reset_pcsrc", PCSrc, 0);
    check("movpc_reset_regwrite", RegWrite, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
